// File: rtl/packet_collector.sv
// Store-and-forward collector: buffers one TLP or DLLP payload, validates
// framing and length, then drains it downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   byte_valid            qualifies data_in, type_in and ctx_in
//   data_in [7:0]         classified byte from the upstream checker
//   type_in [2:0]         byte class (data, starts, ends, edb, not_valid)
//   ctx_in  [1:0]         next framing context from the checker
//   ctx_q   [1:0]         registered context, fed back to the checker
//   out_data/valid/sop/eop/kind, out_ready   drain side handshake
//   err_overflow, err_len, err_framing, err_busy, pkt_drop   event pulses
module packet_collector #(
    parameter int MAX_LEN  = 64,
    parameter int DLLP_LEN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] type_in,
    input  logic [1:0] ctx_in,
    output logic [1:0] ctx_q,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] out_kind,
    input  logic       out_ready,
    output logic       err_overflow,
    output logic       err_len,
    output logic       err_framing,
    output logic       err_busy,
    output logic       pkt_drop
);

    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] T_DATA   = 3'b000;
    localparam logic [2:0] T_TSTART = 3'b001;
    localparam logic [2:0] T_TEND   = 3'b010;
    localparam logic [2:0] T_DSTART = 3'b011;
    localparam logic [2:0] T_DEND   = 3'b100;
    localparam logic [2:0] T_EDB    = 3'b101;

    localparam logic [1:0] K_TLP  = 2'b01;
    localparam logic [1:0] K_DLLP = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t        state, state_d;
    logic [LW-1:0] len, len_d;
    logic [LW-1:0] rd, rd_d;
    logic [1:0]    kind, kind_d;
    logic          wr_en;
    logic          ovf_d, len_err_d, frm_d, busy_d, drop_d;
    logic          last;
    logic [7:0]    mem [MAX_LEN];

    assign last = (rd == len - LW'(1));

    always_comb begin
        state_d   = state;
        len_d     = len;
        rd_d      = rd;
        kind_d    = kind;
        wr_en     = 1'b0;
        ovf_d     = 1'b0;
        len_err_d = 1'b0;
        frm_d     = 1'b0;
        busy_d    = 1'b0;
        drop_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (byte_valid && type_in == T_TSTART) begin
                    state_d = COLLECT;
                    kind_d  = K_TLP;
                    len_d   = '0;
                end else if (byte_valid && type_in == T_DSTART) begin
                    state_d = COLLECT;
                    kind_d  = K_DLLP;
                    len_d   = '0;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    case (type_in)
                        T_DATA: begin
                            if (len == LW'(MAX_LEN)) begin
                                ovf_d   = 1'b1;
                                state_d = IDLE;
                            end else begin
                                wr_en = 1'b1;
                                len_d = len + LW'(1);
                            end
                        end
                        T_TEND: begin
                            state_d = IDLE;
                            if (kind != K_TLP) begin
                                frm_d = 1'b1;
                            end else if (len != '0) begin
                                state_d = DRAIN;
                            end else begin
                                len_err_d = 1'b1;
                            end
                        end
                        T_DEND: begin
                            state_d = IDLE;
                            if (kind != K_DLLP) begin
                                frm_d = 1'b1;
                            end else if (len == LW'(DLLP_LEN)) begin
                                state_d = DRAIN;
                            end else begin
                                len_err_d = 1'b1;
                            end
                        end
                        T_EDB: begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end
                        // A new start aborts the current packet but is
                        // itself kept, so the new packet loses nothing.
                        T_TSTART: begin
                            frm_d  = 1'b1;
                            kind_d = K_TLP;
                            len_d  = '0;
                        end
                        T_DSTART: begin
                            frm_d  = 1'b1;
                            kind_d = K_DLLP;
                            len_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            DRAIN: begin
                if (byte_valid &&
                    (type_in == T_TSTART || type_in == T_DSTART)) begin
                    busy_d = 1'b1;
                end
                if (out_ready) begin
                    if (last) begin
                        state_d = IDLE;
                        rd_d    = '0;
                    end else begin
                        rd_d = rd + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            len          <= '0;
            rd           <= '0;
            kind         <= '0;
            ctx_q        <= '0;
            err_overflow <= 1'b0;
            err_len      <= 1'b0;
            err_framing  <= 1'b0;
            err_busy     <= 1'b0;
            pkt_drop     <= 1'b0;
        end else begin
            state        <= state_d;
            len          <= len_d;
            rd           <= rd_d;
            kind         <= kind_d;
            err_overflow <= ovf_d;
            err_len      <= len_err_d;
            err_framing  <= frm_d;
            err_busy     <= busy_d;
            pkt_drop     <= drop_d;
            if (byte_valid) begin
                ctx_q <= ctx_in;
            end
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len[AW-1:0]] <= data_in;
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_sop   = out_valid && (rd == '0);
    assign out_eop   = out_valid && last;
    assign out_kind  = out_valid ? kind : 2'b00;
    assign out_data  = out_valid ? mem[rd[AW-1:0]] : 8'h00;

endmodule
